// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 4-way muxed resource between four requesters.
// Drives a one-hot grant plus the 2-bit select of the downstream mux4_1.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | no grant active, o_sel holds the last grantee, waiting for req
//   S_GRANT | one requester owns the resource, hold counter running
module mux_rr_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i_req,
    input  logic       i_done,
    output logic [3:0] o_grant,
    output logic [1:0] o_sel,
    output logic       o_busy,
    output logic       o_timeout_err
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    logic [0:0]       r_state;
    logic [3:0]       r_grant;
    logic [1:0]       r_sel;
    logic [1:0]       r_ptr;
    logic [CNT_W-1:0] r_hold_cnt;
    logic             r_timeout_err;

    logic [1:0]       w_next_ptr;
    logic [1:0]       w_arb_ptr;
    logic [1:0]       w_win;
    logic             w_any_req;

    // Scan from the highest offset down so the closest set bit to ptr wins.
    function automatic logic [1:0] f_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        f_pick = ptr;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) f_pick = idx;
        end
    endfunction

    assign w_next_ptr = r_sel + 2'd1;
    // On done the release and re-arbitration share one edge, so use the new ptr.
    assign w_arb_ptr  = (r_state == S_GRANT && i_done) ? w_next_ptr : r_ptr;
    assign w_win      = f_pick(i_req, w_arb_ptr);
    assign w_any_req  = |i_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_grant       <= 4'b0000;
            r_sel         <= 2'd0;
            r_ptr         <= 2'd0;
            r_hold_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_grant    <= 4'b0001 << w_win;
                        r_sel      <= w_win;
                        r_hold_cnt <= '0;
                        r_state    <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (i_done) begin
                        r_ptr      <= w_next_ptr;
                        r_hold_cnt <= '0;
                        if (w_any_req) begin
                            r_grant <= 4'b0001 << w_win;
                            r_sel   <= w_win;
                        end else begin
                            r_grant <= 4'b0000;
                            r_state <= S_IDLE;
                        end
                    end else if (!i_req[r_sel]) begin
                        r_grant <= 4'b0000;
                        r_ptr   <= w_next_ptr;
                        r_state <= S_IDLE;
                    end else if (r_hold_cnt == HOLD_LAST) begin
                        r_grant       <= 4'b0000;
                        r_ptr         <= w_next_ptr;
                        r_timeout_err <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_grant <= 4'b0000;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_grant       = r_grant;
    assign o_sel         = r_sel;
    assign o_busy        = |r_grant;
    assign o_timeout_err = r_timeout_err;

endmodule
